// File: rtl/instr_decode_ctrl_pkg.sv
// Shared definitions for the instruction decode/control stage.
// No logic and no latency; holds the state enum, opcode, ALU ext, flag and condition encodings.
// No flow control lives here.
package instr_decode_ctrl_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DECODE  = 2'd1,
        EXECUTE = 2'd2,
        HALT    = 2'd3
    } state_t;

    // Primary opcodes, instruction bits [15:12]
    localparam logic [3:0] OPC_RTYPE = 4'h0;
    localparam logic [3:0] OPC_ANDI  = 4'h1;
    localparam logic [3:0] OPC_ORI   = 4'h2;
    localparam logic [3:0] OPC_XORI  = 4'h3;
    localparam logic [3:0] OPC_ADDI  = 4'h5;
    localparam logic [3:0] OPC_SUBI  = 4'h9;
    localparam logic [3:0] OPC_CMPI  = 4'hB;
    localparam logic [3:0] OPC_BCOND = 4'hC;
    localparam logic [3:0] OPC_MOVI  = 4'hD;
    localparam logic [3:0] OPC_HALT  = 4'hF;

    // R-type ext field, instruction bits [7:4]
    localparam logic [3:0] EXT_AND  = 4'h1;
    localparam logic [3:0] EXT_OR   = 4'h2;
    localparam logic [3:0] EXT_XOR  = 4'h3;
    localparam logic [3:0] EXT_ADD  = 4'h5;
    localparam logic [3:0] EXT_ADDC = 4'h7;
    localparam logic [3:0] EXT_SUB  = 4'h9;
    localparam logic [3:0] EXT_SUBC = 4'hA;
    localparam logic [3:0] EXT_CMP  = 4'hB;
    localparam logic [3:0] EXT_MOV  = 4'hD;

    // Bit positions in the datapath flag register {N,Z,F,L,C}
    localparam int FLAG_C = 0;
    localparam int FLAG_L = 1;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 4;

    // Branch condition codes, instruction bits [11:8]
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h6;
    localparam logic [3:0] COND_PL = 4'h7;
    localparam logic [3:0] COND_UC = 4'hE;

    // Opcodes whose B operand comes from the immediate.
    function automatic logic is_imm_form(input logic [3:0] opc);
        return opc inside {OPC_ANDI, OPC_ORI, OPC_XORI, OPC_ADDI,
                           OPC_SUBI, OPC_CMPI, OPC_MOVI};
    endfunction

    // Arithmetic immediates take a signed imm8; the logical ones and MOVI take it unsigned.
    function automatic logic is_sext_form(input logic [3:0] opc);
        return opc inside {OPC_ADDI, OPC_SUBI, OPC_CMPI};
    endfunction

endpackage

// File: rtl/instr_decode_ctrl_branch_cond_eval.sv
// Branch condition evaluator: cond[3:0] and flags[4:0] in, taken out.
// Purely combinational, zero latency.
// No flow control; codes not listed below are never taken.
module branch_cond_eval
    import instr_decode_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [4:0] flags,
    output logic       taken
);

    // L and F play no part in any branch condition.
    logic flags_unused;
    assign flags_unused = flags[FLAG_L] ^ flags[FLAG_F];

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_EQ: taken =  flags[FLAG_Z];
            COND_NE: taken = ~flags[FLAG_Z];
            COND_CS: taken =  flags[FLAG_C];
            COND_CC: taken = ~flags[FLAG_C];
            COND_MI: taken =  flags[FLAG_N];
            COND_PL: taken = ~flags[FLAG_N];
            COND_UC: taken =  1'b1;
            default: taken =  1'b0;
        endcase
    end

endmodule

// File: rtl/instr_decode_ctrl.sv
// Fetch/decode/execute controller that owns the PC and drives every ALU/regfile control input.
// Latency: 3 cycles per instruction (FETCH accept, DECODE, EXECUTE); write strobes last one cycle.
// Backpressure: ins_ready is high only in FETCH, and not in the first cycle after reset.
// Ports: clk/Reset (async, active low); pc_out/ins_valid/ins_data/ins_ready carry the fetch handshake;
//        Flag_Reg_Output carries flags in; the select/Immediate/strobe/OP/cin outputs go to the datapath; halted.
// Optional: define SINGLE_STEP_EN to add input step. Each rising edge of step then admits one fetch.
module instr_decode_ctrl
    import instr_decode_ctrl_pkg::*;
#(
    parameter int                     PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0]    RESET_PC = '0
) (
    input  logic                clk,
    input  logic                Reset,
`ifdef SINGLE_STEP_EN
    input  logic                step,
`endif
    output logic [PC_WIDTH-1:0] pc_out,
    input  logic                ins_valid,
    input  logic [15:0]         ins_data,
    output logic                ins_ready,
    input  logic [4:0]          Flag_Reg_Output,
    output logic [3:0]          A_Mux_input,
    output logic [3:0]          B_Mux_input,
    output logic [3:0]          Reg_Enable,
    output logic                Reg_Write,
    output logic                Imm_mux_input,
    output logic [15:0]         Immediate,
    output logic                Tri_Enable,
    output logic                Flags_Enable,
    output logic [7:0]          OP,
    output logic                cin,
    output logic                halted
);

    state_t              state;
    state_t              state_nxt;
    logic [15:0]         ir;
    logic [PC_WIDTH-1:0] pc;
    logic                run;      // low in the first cycle after reset, which keeps ins_ready low then
    logic                fire;
    logic                taken;
    logic                fetch_ok;

    logic [3:0] opc, rdest, ext, rsrc;
    logic [7:0] imm8;
    assign opc   = ir[15:12];
    assign rdest = ir[11:8];
    assign ext   = ir[7:4];
    assign rsrc  = ir[3:0];
    assign imm8  = ir[7:0];

`ifdef SINGLE_STEP_EN
    logic step_q;
    logic step_pend;
    assign fetch_ok = step_pend;
`else
    assign fetch_ok = 1'b1;
`endif

    assign ins_ready = (state == FETCH) && run && fetch_ok;
    assign fire      = ins_ready && ins_valid;
    assign halted    = (state == HALT);
    assign pc_out    = pc;

    branch_cond_eval u_branch_cond_eval (
        .cond  (rdest),
        .flags (Flag_Reg_Output),
        .taken (taken)
    );

    logic [PC_WIDTH-1:0] br_off;
    assign br_off = PC_WIDTH'($signed(imm8));

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state <= FETCH;
            pc    <= RESET_PC;
            ir    <= '0;
            run   <= 1'b0;
        end else begin
            run   <= 1'b1;
            state <= state_nxt;
            if (fire)
                ir <= ins_data;
            if (state == EXECUTE && opc != OPC_HALT) begin
                if (opc == OPC_BCOND && taken)
                    pc <= pc + br_off;
                else
                    pc <= pc + 1'b1;
            end
        end
    end

`ifdef SINGLE_STEP_EN
    // A step edge seen outside FETCH stays pending until the next fetch consumes it.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            step_q    <= 1'b0;
            step_pend <= 1'b0;
        end else begin
            step_q    <= step;
            step_pend <= (step_pend & ~fire) | (step & ~step_q);
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH:   if (fire) state_nxt = DECODE;
            DECODE:  state_nxt = EXECUTE;
            EXECUTE: state_nxt = (opc == OPC_HALT) ? HALT : FETCH;
            HALT:    state_nxt = HALT;
            default: state_nxt = FETCH;
        endcase
    end

    // Decoded controls hold through DECODE and EXECUTE; only EXECUTE asserts the strobes.
    logic alu_op, no_write, no_flags;

    always_comb begin
        A_Mux_input   = '0;
        B_Mux_input   = '0;
        Reg_Enable    = '0;
        Imm_mux_input = 1'b0;
        Immediate     = '0;
        OP            = '0;
        cin           = 1'b0;
        Tri_Enable    = 1'b0;
        Reg_Write     = 1'b0;
        Flags_Enable  = 1'b0;
        alu_op        = 1'b0;
        no_write      = 1'b0;
        no_flags      = 1'b0;
        if (state == DECODE || state == EXECUTE) begin
            A_Mux_input = rdest;
            B_Mux_input = rsrc;
            Reg_Enable  = rdest;
            if (opc == OPC_RTYPE) begin
                alu_op   = 1'b1;
                OP       = {opc, ext};
                cin      = (ext == EXT_ADDC || ext == EXT_SUBC) && Flag_Reg_Output[FLAG_C];
                no_write = (ext == EXT_CMP);
                no_flags = ext inside {EXT_AND, EXT_OR, EXT_XOR, EXT_MOV};
            end else if (is_imm_form(opc)) begin
                alu_op        = 1'b1;
                OP            = {opc, 4'h0};
                Imm_mux_input = 1'b1;
                Immediate     = is_sext_form(opc) ? 16'($signed(imm8)) : {8'h00, imm8};
                no_write      = (opc == OPC_CMPI);
                no_flags      = opc inside {OPC_ANDI, OPC_ORI, OPC_XORI, OPC_MOVI};
            end
            if (state == EXECUTE && alu_op) begin
                Tri_Enable   = ~no_write;
                Reg_Write    = ~no_write;
                Flags_Enable = ~no_flags;
            end
        end
    end

endmodule

// File: tb/tb_instr_decode_ctrl.sv
// Directed testbench for instr_decode_ctrl: reset, ALU/immediate decode, carry-in, branches, HALT, mid-instruction reset.
// Inputs are driven and outputs sampled 1 time unit after each rising clock edge.
// Ends with one summary line.
module tb_instr_decode_ctrl;

    logic        clk = 1'b0;
    logic        Reset = 1'b0;
    logic        step = 1'b0;
    logic [15:0] pc_out;
    logic        ins_valid = 1'b0;
    logic [15:0] ins_data = 16'h0000;
    logic        ins_ready;
    logic [4:0]  Flag_Reg_Output = 5'b00000;
    logic [3:0]  A_Mux_input, B_Mux_input, Reg_Enable;
    logic        Reg_Write, Imm_mux_input, Tri_Enable, Flags_Enable, cin, halted;
    logic [15:0] Immediate;
    logic [7:0]  OP;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    instr_decode_ctrl #(.PC_WIDTH(16), .RESET_PC(16'h0000)) dut (
        .clk             (clk),
        .Reset           (Reset),
`ifdef SINGLE_STEP_EN
        .step            (step),
`endif
        .pc_out          (pc_out),
        .ins_valid       (ins_valid),
        .ins_data        (ins_data),
        .ins_ready       (ins_ready),
        .Flag_Reg_Output (Flag_Reg_Output),
        .A_Mux_input     (A_Mux_input),
        .B_Mux_input     (B_Mux_input),
        .Reg_Enable      (Reg_Enable),
        .Reg_Write       (Reg_Write),
        .Imm_mux_input   (Imm_mux_input),
        .Immediate       (Immediate),
        .Tri_Enable      (Tri_Enable),
        .Flags_Enable    (Flags_Enable),
        .OP              (OP),
        .cin             (cin),
        .halted          (halted)
    );

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Offer one word in FETCH; returns in DECODE.
    task automatic issue(input logic [15:0] w);
        ins_data  = w;
        ins_valid = 1'b1;
        tick();
        ins_valid = 1'b0;
    endtask

    task automatic run_nops(input int n);
        for (int i = 0; i < n; i++) begin
            issue(16'h4000);
            tick();
            tick();
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        tick(); tick(); tick();
        n_checks++;
        if ({pc_out, halted, ins_ready, Reg_Write, Tri_Enable, Flags_Enable, OP, Imm_mux_input} !== 30'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: pc=%h halted=%b rdy=%b rw=%b tri=%b fe=%b op=%h imm=%b, all required 0",
                     pc_out, halted, ins_ready, Reg_Write, Tri_Enable, Flags_Enable, OP, Imm_mux_input);
        end
        Reset = 1'b1;
        tick();
        n_checks++;
        if ({ins_ready, pc_out} !== {1'b1, 16'h0000}) begin
            n_fail++;
            $display("FAIL reset_release: rdy=%b pc=%h, required rdy=1 pc=0000", ins_ready, pc_out);
        end
    endtask

    task automatic test_add();
        issue(16'h0351);
        n_checks++;
        if ({A_Mux_input, B_Mux_input, OP, Imm_mux_input, cin, Tri_Enable, Reg_Write, Flags_Enable} !== {4'd3, 4'd1, 8'h05, 5'b00000}) begin
            n_fail++;
            $display("FAIL add_decode: A=%h B=%h OP=%h imm=%b cin=%b tri=%b rw=%b fe=%b, required A=3 B=1 OP=05 rest 0",
                     A_Mux_input, B_Mux_input, OP, Imm_mux_input, cin, Tri_Enable, Reg_Write, Flags_Enable);
        end
        tick();
        n_checks++;
        if ({Reg_Write, Tri_Enable, Flags_Enable, Reg_Enable} !== {3'b111, 4'd3}) begin
            n_fail++;
            $display("FAIL add_execute: rw=%b tri=%b fe=%b re=%h, required 1 1 1 3",
                     Reg_Write, Tri_Enable, Flags_Enable, Reg_Enable);
        end
        tick();
        n_checks++;
        if ({pc_out, Reg_Write, ins_ready} !== {16'd1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL add_pc: pc=%h rw=%b rdy=%b, required pc=0001 rw=0 rdy=1", pc_out, Reg_Write, ins_ready);
        end
    endtask

    task automatic test_immediates();
        issue(16'h52FF);   // ADDI r2,-1
        n_checks++;
        if ({Immediate, Imm_mux_input, OP, A_Mux_input} !== {16'hFFFF, 1'b1, 8'h50, 4'd2}) begin
            n_fail++;
            $display("FAIL addi_decode: imm=%h sel=%b OP=%h A=%h, required FFFF 1 50 2", Immediate, Imm_mux_input, OP, A_Mux_input);
        end
        tick();
        n_checks++;
        if ({Flags_Enable, Reg_Write, Tri_Enable, Immediate} !== {3'b111, 16'hFFFF}) begin
            n_fail++;
            $display("FAIL addi_execute: fe=%b rw=%b tri=%b imm=%h, required 1 1 1 FFFF", Flags_Enable, Reg_Write, Tri_Enable, Immediate);
        end
        tick();
        issue(16'h12FF);   // ANDI r2,0xFF
        n_checks++;
        if ({Immediate, Imm_mux_input, OP} !== {16'h00FF, 1'b1, 8'h10}) begin
            n_fail++;
            $display("FAIL andi_decode: imm=%h sel=%b OP=%h, required 00FF 1 10", Immediate, Imm_mux_input, OP);
        end
        tick();
        n_checks++;
        if ({Flags_Enable, Reg_Write, Tri_Enable} !== 3'b011) begin
            n_fail++;
            $display("FAIL andi_execute: fe=%b rw=%b tri=%b, required 0 1 1", Flags_Enable, Reg_Write, Tri_Enable);
        end
        tick();
        issue(16'hB203);   // CMPI r2,3
        n_checks++;
        if ({Immediate, OP, Tri_Enable, Reg_Write, Flags_Enable} !== {16'h0003, 8'hB0, 3'b000}) begin
            n_fail++;
            $display("FAIL cmpi_decode: imm=%h OP=%h strobes=%b%b%b, required 0003 B0 000", Immediate, OP, Tri_Enable, Reg_Write, Flags_Enable);
        end
        tick();
        n_checks++;
        if ({Flags_Enable, Reg_Write, Tri_Enable} !== 3'b100) begin
            n_fail++;
            $display("FAIL cmpi_execute: fe=%b rw=%b tri=%b, required 1 0 0", Flags_Enable, Reg_Write, Tri_Enable);
        end
        tick();
        n_checks++;
        if (pc_out !== 16'd4) begin
            n_fail++;
            $display("FAIL imm_pc: pc=%h, required 0004", pc_out);
        end
    endtask

    task automatic test_carry_in();
        Flag_Reg_Output = 5'b00001;   // C=1
        issue(16'h0371);              // ADDC r3,r1
        n_checks++;
        if ({cin, OP} !== {1'b1, 8'h07}) begin
            n_fail++;
            $display("FAIL addc_cin: cin=%b OP=%h, required 1 07", cin, OP);
        end
        tick(); tick();
        issue(16'h0351);              // ADD r3,r1 ignores C
        n_checks++;
        if (cin !== 1'b0) begin
            n_fail++;
            $display("FAIL add_cin: cin=%b, required 0", cin);
        end
        tick(); tick();
        Flag_Reg_Output = 5'b00000;
        n_checks++;
        if (pc_out !== 16'd6) begin
            n_fail++;
            $display("FAIL cin_pc: pc=%h, required 0006", pc_out);
        end
    endtask

    task automatic test_branch();
        run_nops(4);                  // pc 6 -> 10
        n_checks++;
        if (pc_out !== 16'd10) begin
            n_fail++;
            $display("FAIL nop_pc: pc=%h, required 000A", pc_out);
        end
        Flag_Reg_Output = 5'b01000;   // Z=1
        issue(16'hC0FC);              // BEQ -4
        tick();
        n_checks++;
        if ({Reg_Write, Tri_Enable, Flags_Enable} !== 3'b000) begin
            n_fail++;
            $display("FAIL branch_strobes: rw=%b tri=%b fe=%b, required 000", Reg_Write, Tri_Enable, Flags_Enable);
        end
        tick();
        n_checks++;
        if (pc_out !== 16'd6) begin
            n_fail++;
            $display("FAIL beq_taken: pc=%h, required 0006", pc_out);
        end
        run_nops(4);
        Flag_Reg_Output = 5'b00000;   // Z=0
        issue(16'hC0FC);
        tick(); tick();
        n_checks++;
        if (pc_out !== 16'd11) begin
            n_fail++;
            $display("FAIL beq_not_taken: pc=%h, required 000B", pc_out);
        end
        Flag_Reg_Output = 5'b11111;   // cond 0100 is never taken, whatever the flags
        issue(16'hC4FC);
        tick(); tick();
        n_checks++;
        if (pc_out !== 16'd12) begin
            n_fail++;
            $display("FAIL undefined_cond: pc=%h, required 000C", pc_out);
        end
        Flag_Reg_Output = 5'b00000;
        issue(16'hCE02);              // unconditional +2
        tick(); tick();
        n_checks++;
        if (pc_out !== 16'd14) begin
            n_fail++;
            $display("FAIL uncond_branch: pc=%h, required 000E", pc_out);
        end
    endtask

    task automatic test_halt();
        int bad;
        issue(16'hF000);
        tick();
        n_checks++;
        if ({Reg_Write, Tri_Enable, Flags_Enable, halted} !== 4'b0000) begin
            n_fail++;
            $display("FAIL halt_execute: rw=%b tri=%b fe=%b halted=%b, required 0000", Reg_Write, Tri_Enable, Flags_Enable, halted);
        end
        tick();
        n_checks++;
        if ({halted, ins_ready, pc_out} !== {1'b1, 1'b0, 16'd14}) begin
            n_fail++;
            $display("FAIL halt_state: halted=%b rdy=%b pc=%h, required 1 0 000E", halted, ins_ready, pc_out);
        end
        bad = 0;
        ins_data  = 16'h0351;
        ins_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ins_ready !== 1'b0 || Reg_Write !== 1'b0 || halted !== 1'b1 || pc_out !== 16'd14) bad++;
        end
        ins_valid = 1'b0;
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL halt_hold: %0d cycles left the halt state or fetched, required 0", bad);
        end
    endtask

    task automatic test_reset_mid_execute();
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
        n_checks++;
        if ({halted, ins_ready, pc_out} !== {1'b0, 1'b1, 16'd0}) begin
            n_fail++;
            $display("FAIL halt_exit_reset: halted=%b rdy=%b pc=%h, required 0 1 0000", halted, ins_ready, pc_out);
        end
        issue(16'h0351);
        tick();
        n_checks++;
        if (Reg_Write !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_pre: rw=%b, required 1", Reg_Write);
        end
        #2 Reset = 1'b0;
        #1;
        n_checks++;
        if ({Reg_Write, Tri_Enable, pc_out} !== {2'b00, 16'd0}) begin
            n_fail++;
            $display("FAIL mid_reset_abort: rw=%b tri=%b pc=%h, required 0 0 0000", Reg_Write, Tri_Enable, pc_out);
        end
        tick();
        Reset = 1'b1;
        tick(); tick();
        n_checks++;
        if ({ins_ready, pc_out, Reg_Write} !== {1'b1, 16'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_reset_recover: rdy=%b pc=%h rw=%b, required 1 0000 0", ins_ready, pc_out, Reg_Write);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_immediates();
        test_carry_in();
        test_branch();
        test_halt();
        test_reset_mid_execute();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_decode_ctrl.md
Name: instr_decode_ctrl

Overview:
- Control stage directly upstream of the ALU/register-file datapath.
- Fetches 16-bit instructions from instruction memory over a valid/ready handshake and decodes them.
- Sequences FETCH/DECODE/EXECUTE and drives every datapath control input: register selects, immediate, mux select, bus enable, write strobe, flag enable, OP, cin.
- Consumes the datapath's 5-bit flag register for conditional branches and owns the PC.

Parameters:
- PC_WIDTH, 16, program counter width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk, input, 1, system clock, rising edge.
- Reset, input, 1, asynchronous active-low reset.
- pc_out, output, PC_WIDTH, instruction fetch address.
- ins_valid, input, 1, ins_data holds the word at pc_out.
- ins_data, input, 16, instruction word.
- ins_ready, output, 1, high in FETCH.
- Flag_Reg_Output, input, 5, datapath flags: {N,Z,F,L,C}, bit0 is C.
- A_Mux_input, output, 4, A register select.
- B_Mux_input, output, 4, B register select.
- Reg_Enable, output, 4, destination register index.
- Reg_Write, output, 1, one-cycle register write strobe.
- Imm_mux_input, output, 1, 1 selects Immediate for the B operand.
- Immediate, output, 16, extended imm8.
- Tri_Enable, output, 1, ALU drives result bus.
- Flags_Enable, output, 1, flag register load.
- OP, output, 8, ALU opcode.
- cin, output, 1, ALU carry-in.
- halted, output, 1, HALT executed.

Behaviour:
- Reset (async, Reset=0):
  - State=FETCH, pc_out=RESET_PC, halted=0.
  - All control outputs 0. ins_ready goes to 1 once Reset deasserts.
- Instruction format:
  - [15:12] opc, [11:8] Rdest/cond, [7:4] ext, [3:0] Rsrc, [7:0] imm8.
- FETCH:
  - ins_ready=1; ins_data is latched into the IR when ins_valid=1 on a clock edge.
  - Then go to DECODE. With no ins_valid, stay in FETCH.
- DECODE (1 cycle), combinational from the IR:
  - A_Mux_input=Rdest; B_Mux_input=Rsrc; Reg_Enable=Rdest.
  - opc=0000 (R-type): OP={opc,ext}, Imm_mux_input=0.
  - opc in {0001,0010,0011,0101,1001,1011,1101} (immediate forms):
    - OP={opc,4'h0}, Imm_mux_input=1.
    - Immediate=sign-extended imm8 for 0101/1001/1011; zero-extended for the others.
  - cin=C only when opc=0000 and ext is 0111 or 1010; else 0.
  - Strobes Tri_Enable/Reg_Write/Flags_Enable stay 0.
- EXECUTE (1 cycle), selects/OP/Immediate held from DECODE:
  - Tri_Enable=1 and Reg_Write=1 for every ALU instruction except CMP (R-type ext 1011) and CMPI.
  - Flags_Enable=1 for ALU instructions except AND/OR/XOR/MOV forms.
  - PC increments by 1 (wraps at 2^PC_WIDTH).
  - Next state is FETCH.
- Branch (opc 1100):
  - No datapath strobes asserted.
  - Condition from [11:8]: 0000 Z=1; 0001 Z=0; 0010 C=1; 0011 C=0; 0110 N=1; 0111 N=0; 1110 always. All other codes are never taken.
  - Taken: PC += sign-extended imm8 (modulo wrap). Not taken: PC += 1.
  - Flags are sampled in EXECUTE.
- HALT (opc 1111):
  - Enters HALT state; halted=1, ins_ready=0, all strobes 0.
  - Left only by reset.
- Undefined opcodes (0100, 0110, 0111, 1000, 1010, 1110) execute as NOP: PC+1, no strobes.
- Strobes are single-cycle; the minimum instruction period is 3 cycles.
- Reset mid-instruction aborts the instruction with no write.

Optional Feature:
- Macro SINGLE_STEP_EN.
  - Defined: adds input step (1 bit). FETCH asserts ins_ready only after a rising edge of step has been registered. Each step pulse admits exactly one instruction. A pulse arriving during DECODE/EXECUTE is held for the next FETCH.
  - Undefined: no step port; free-running fetch.

Decomposition:
- Shared package holds:
  - state enum {FETCH, DECODE, EXECUTE, HALT};
  - opcode constants and R-type ext constants (CMP=1011, ADDC=0111, SUBC=1010);
  - flag bit indices (C=0, L=1, F=2, Z=3, N=4);
  - condition-code constants.
- One sub-module, branch_cond_eval: combinational cond[3:0] plus flags[4:0] gives a taken signal.

Test Plan:
- Reset held low then released, RESET_PC=0 -> pc_out=0, all strobes 0, ins_ready=1 the next cycle.
- ins_data=0x0351 (ADD r3,r1) with ins_valid -> DECODE A=3, B=1, OP=0x05, Imm_mux_input=0; EXECUTE Reg_Write=1, Tri_Enable=1, Flags_Enable=1, Reg_Enable=3; pc_out=1.
- 0x52FF (ADDI r2,-1) -> Immediate=0xFFFF, Imm_mux_input=1, OP=0x50; 0x12FF (ANDI) -> Immediate=0x00FF, Flags_Enable=0.
- Flags Z=1, 0xC0FC at PC=10 -> pc_out=6; same instruction with Z=0 -> pc_out=11.
- 0xB203 (CMPI) -> Flags_Enable=1, Reg_Write=0, Tri_Enable=0. 0xF000 -> halted=1, ins_ready=0, no further fetch for 20 cycles.
- Reset asserted during EXECUTE of an ADD -> Reg_Write drops immediately, pc_out=RESET_PC.
